// File: rtl/div_pkg.sv
// Shared definitions for the restoring-divider controller: state encoding, default width, counter sizing.
// Imported by ctrl_div and cnt_div; holds no logic.
package div_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    SHIFT = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/ctrl_div_if.sv
// Host/datapath-facing bundle of the divider controller; master = host + datapath, slave = controller.
// Strobes are registered in the controller; the datapath is expected to act on them at the negedge.
interface ctrl_div_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             a_ge_d;
  logic             dvsr_zero;
  logic             init;
  logic             sh;
  logic             load_A;
  logic [WIDTH-1:0] quotient;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, a_ge_d, dvsr_zero,
    input  init, sh, load_A, quotient, busy, done, err
  );

  modport slave (
    input  start, a_ge_d, dvsr_zero,
    output init, sh, load_A, quotient, busy, done, err
  );
endinterface

// File: rtl/cnt_div.sv
// Iteration counter: clear, enable, terminal flag at WIDTH-1; wraps to 0 after the terminal count.
// Single-cycle update, no backpressure.
module cnt_div #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);
  logic [CNT_W-1:0] cnt;

  assign last = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ctrl_div.sv
// Restoring-divider sequencer: INIT, WIDTH x (SHIFT, CHECK), DONE; done 2*WIDTH+2 cycles after start.
// Starts arriving outside IDLE are dropped; DIV_ZERO_EN enables the divide-by-zero early exit.
module ctrl_div
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic         clk,
  input  logic         rst,
  ctrl_div_if.slave    bus
);
  state_t state;
  logic   ge_q;
  logic   last;

  cnt_div #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == INIT),
    .en   (state == CHECK),
    .last (last)
  );

  // Strobes are registered alongside the next state so they decode purely from flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      ge_q         <= 1'b0;
      bus.init     <= 1'b0;
      bus.sh       <= 1'b0;
      bus.load_A   <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
      bus.quotient <= '0;
    end else begin
      bus.init   <= 1'b0;
      bus.sh     <= 1'b0;
      bus.load_A <= 1'b0;
      bus.done   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= INIT;
            bus.init <= 1'b1;
            bus.busy <= 1'b1;
          end
        end
        INIT: begin
          bus.quotient <= '0;
          bus.err      <= 1'b0;
          state        <= SHIFT;
          bus.sh       <= 1'b1;
`ifdef DIV_ZERO_EN
          if (bus.dvsr_zero) begin
            bus.err      <= 1'b1;
            bus.quotient <= '1;
            state        <= DONE;
            bus.sh       <= 1'b0;
            bus.done     <= 1'b1;
            bus.busy     <= 1'b0;
          end
`endif
        end
        SHIFT: begin
          // A settled at the negedge inside SHIFT; it moves again inside CHECK.
          ge_q       <= bus.a_ge_d;
          bus.load_A <= bus.a_ge_d;
          state      <= CHECK;
        end
        CHECK: begin
          bus.quotient <= {bus.quotient[WIDTH-2:0], ge_q};
          if (last) begin
            state    <= DONE;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
          end else begin
            state  <= SHIFT;
            bus.sh <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ctrl_div.sv
// Bench for ctrl_div: negedge-acting restoring datapath model, per-cycle timeline model, randomized operands.
module tb_ctrl_div;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  ctrl_div_if #(.WIDTH(16)) bus();

  ctrl_div #(.WIDTH(16), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Datapath: A/dividend shift register and subtractor, acting on the negedge.
  logic [16:0] A = '0;
  logic [15:0] dv = '0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = 16'd1;

  always @(negedge clk) begin
    if (bus.init) begin
      A  <= '0;
      dv <= dividend;
    end else if (bus.sh) begin
      {A, dv} <= {A[15:0], dv, 1'b0};
    end else if (bus.load_A) begin
      A <= A - {1'b0, divisor};
    end
  end

  assign bus.a_ge_d    = (A >= {1'b0, divisor});
  assign bus.dvsr_zero = (divisor == 16'd0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected outputs k cycles after the cycle in which start was first seen high.
  function automatic logic [21:0] model(input bit on, input int k, input logic [15:0] qe,
                                        input logic [15:0] qp, input logic eh);
    logic i, s, l, b, d, e;
    logic [15:0] q;
    int n;
    i = 1'b0; s = 1'b0; l = 1'b0; b = 1'b0; d = 1'b0; e = eh; q = qp;
    if (on && k == 1) begin
      i = 1'b1;
      b = 1'b1;
    end
    if (on && k >= 2 && k <= 33) begin
      b = 1'b1;
      s = (k % 2 == 0);
      if (k % 2 == 1) l = qe[15 - (k - 3) / 2];
    end
    if (on && k >= 2) begin
      e = 1'b0;
      n = (k - 2) / 2;
      if (n > 16) n = 16;
      q = 16'((32'(qe)) >> (16 - n));
    end
    if (on && k == 34) d = 1'b1;
    return {e, i, s, l, b, d, q};
  endfunction

  bit          chk_en = 1'b0;
  bit          run_on = 1'b0;
  int          t0 = 0;
  int          k;
  logic [15:0] q_exp = '0;
  logic [15:0] q_prev = '0;
  logic [15:0] q_hold = '0;
  logic        err_hold = 1'b0;
  logic [21:0] exp_v, act_v;
  int          sh_cnt = 0, ld_cnt = 0, in_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      k     = run_on ? cyc - t0 : -1;
      exp_v = model(run_on, k, q_exp, run_on ? q_prev : q_hold, err_hold);
      act_v = {bus.err, bus.init, bus.sh, bus.load_A, bus.busy, bus.done, bus.quotient};
      check("outputs{err,init,sh,load_A,busy,done,q}", 32'(act_v), 32'(exp_v));
      check("strobe_onehot", 32'($onehot0({bus.init, bus.sh, bus.load_A})), 32'd1);
      if (run_on && k == 1) begin
        sh_cnt = 0; ld_cnt = 0; in_cnt = 0;
      end
      sh_cnt += int'(bus.sh);
      ld_cnt += int'(bus.load_A);
      in_cnt += int'(bus.init);
      if (run_on && k == 34) begin
        check("sh_count", sh_cnt, 16);
        check("init_count", in_cnt, 1);
        check("load_A_count", ld_cnt, $countones(q_exp));
      end
    end
  end

  // Called at k==1; returns at k==35 with the DUT back in IDLE.
  task automatic finish_run();
    int got;
    got = -1;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        got = cyc - t0;
        break;
      end
      @(posedge clk); #1;
    end
    check("done_cycle", got, 34);
    @(posedge clk); #1;
    if (divisor != 16'd0) check("remainder", 32'(A), 32'(dividend % divisor));
    q_hold   = q_exp;
    err_hold = 1'b0;
    run_on   = 1'b0;
  endtask

  task automatic do_run(input logic [15:0] n, input logic [15:0] d, input int gap);
    repeat (gap) @(posedge clk);
    @(posedge clk); #1;
    dividend  = n;
    divisor   = d;
    q_exp     = (d == 16'd0) ? 16'hFFFF : n / d;
    q_prev    = q_hold;
    t0        = cyc;
    run_on    = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    finish_run();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] n, d;
    bus.start = 1'b0;
    #12;
    check("reset_outputs", 32'({bus.err, bus.init, bus.sh, bus.load_A, bus.busy, bus.done, bus.quotient}), 32'd0);
    @(posedge clk); #1;
    rst    = 1'b1;
    chk_en = 1'b1;

    do_run(16'd100, 16'd7, 1);
    check("q_100_7", 32'(bus.quotient), 32'd14);
    check("rem_100_7", 32'(A), 32'd2);

    do_run(16'd65535, 16'd1, 0);
    check("q_65535_1", 32'(bus.quotient), 32'hFFFF);

    do_run(16'd5, 16'd9, 2);
    check("q_5_9", 32'(bus.quotient), 32'd0);
    check("load_A_5_9", ld_cnt, 0);

    // start held high across a whole run and into the following IDLE cycle.
    @(posedge clk); #1;
    dividend  = 16'd1000;
    divisor   = 16'd3;
    q_exp     = 16'd333;
    q_prev    = q_hold;
    t0        = cyc;
    run_on    = 1'b1;
    bus.start = 1'b1;
    repeat (35) @(posedge clk);
    #1;
    check("hold_q1", 32'(bus.quotient), 32'd333);
    check("hold_rem1", 32'(A), 32'd1);
    q_hold   = 16'd333;
    q_prev   = 16'd333;
    dividend = 16'd40000;
    divisor  = 16'd123;
    q_exp    = 16'd325;
    t0       = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    finish_run();
    check("hold_q2", 32'(bus.quotient), 32'd325);

    // Asynchronous reset in the middle of a CHECK cycle.
    @(posedge clk); #1;
    dividend  = 16'd300;
    divisor   = 16'd11;
    q_exp     = 16'd27;
    q_prev    = q_hold;
    t0        = cyc;
    run_on    = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk_en = 1'b0;
    rst    = 1'b0;
    #1;
    check("midrun_reset", 32'({bus.err, bus.init, bus.sh, bus.load_A, bus.busy, bus.done, bus.quotient}), 32'd0);
    @(negedge clk);
    check("midrun_reset_held", 32'({bus.err, bus.init, bus.sh, bus.load_A, bus.busy, bus.done, bus.quotient}), 32'd0);
    @(posedge clk); #1;
    rst      = 1'b1;
    run_on   = 1'b0;
    q_hold   = '0;
    err_hold = 1'b0;
    chk_en   = 1'b1;
    do_run(16'd300, 16'd11, 1);
    check("q_after_reset", 32'(bus.quotient), 32'd27);

`ifdef DIV_ZERO_EN
    begin
      int got, shs;
      @(posedge clk); #1;
      chk_en    = 1'b0;
      dividend  = 16'd77;
      divisor   = 16'd0;
      t0        = cyc;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      got = -1;
      shs = 0;
      for (int i = 0; i < 6; i++) begin
        shs += int'(bus.sh);
        if (bus.done && got < 0) got = cyc - t0;
        @(posedge clk); #1;
      end
      check("dz_err", 32'(bus.err), 32'd1);
      check("dz_quotient", 32'(bus.quotient), 32'hFFFF);
      check("dz_sh_count", shs, 0);
      check("dz_done_early", 32'(got >= 2 && got <= 3), 32'd1);
      q_hold   = 16'hFFFF;
      err_hold = 1'b1;
      divisor  = 16'd1;
      chk_en   = 1'b1;
    end
`else
    do_run(16'd1234, 16'd0, 1);
    check("dz_err", 32'(bus.err), 32'd0);
    check("dz_quotient", 32'(bus.quotient), 32'hFFFF);
`endif

    for (int r = 0; r < 25; r++) begin
      n = 16'($urandom_range(0, 65535));
      case ($urandom_range(0, 2))
        0:       d = 16'($urandom_range(1, 15));
        1:       d = 16'($urandom_range(1, 65535));
        default: d = 16'($urandom_range(1, 300));
      endcase
      do_run(n, d, $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
